// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl
//   Receive-side UART framing engine that feeds the 8-bit RX data buffer.
//   It synchronises the serial line and detects the falling edge of the start bit.
//   Data bits are sampled at mid-bit and the stop bit is checked.
//   Each good frame is handed to the buffer with a one-cycle load_buffer strobe.
//
//   Optional feature macro: PARITY_CHECK_EN
//     defined   : one even-parity bit follows the data bits. parity_error reports
//                 a mismatch, and the frame is still loaded.
//     undefined : no parity bit on the wire, and parity_error is tied low.
//
// Ports
//   clk            in   1  system clock, rising edge
//   n_rst          in   1  asynchronous active-low reset
//   serial_in      in   1  raw asynchronous RX line, idle high
//   packet_data    out  8  last received byte, bit 0 = first data bit on the wire
//   load_buffer    out  1  one-cycle strobe, packet_data valid
//   framing_error  out  1  stop bit sampled low on the most recent frame (sticky)
//   parity_error   out  1  parity mismatch on the most recent frame (sticky)
//   rx_busy        out  1  high whenever the FSM is not idle
module rx_packet_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  output logic [7:0] packet_data,
  output logic       load_buffer,
  output logic       framing_error,
  output logic       parity_error,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BITS_LAST = 4'(DATA_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef PARITY_CHECK_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] LOAD      = 3'd5;
  localparam logic [2:0] WAIT_IDLE = 3'd6;

  logic          sync_1;
  logic          sync_2;
  logic          sync_3;
  logic          start_edge;
  logic          bit_done;
  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_reg;
`ifdef PARITY_CHECK_EN
  logic          parity_bit;
`else
  assign parity_error = 1'b0;
`endif

  // sync_3 is a one-cycle delayed copy of the synchronised line.
  // A 1 -> 0 transition between sync_3 and sync_2 marks the leading edge of a start bit.
  assign start_edge = sync_3 & ~sync_2;
  assign bit_done   = (clk_cnt == CNT_FULL);
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_1        <= 1'b1;
      sync_2        <= 1'b1;
      sync_3        <= 1'b1;
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      packet_data   <= 8'hFF;
      load_buffer   <= 1'b0;
      framing_error <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_bit    <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      sync_1      <= serial_in;
      sync_2      <= sync_1;
      sync_3      <= sync_2;
      load_buffer <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (start_edge) state <= START;
        end

        // Re-check the start bit at its midpoint.
        // A line that is already high again was a glitch, so the frame is dropped silently.
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            state   <= sync_2 ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // The counter was aligned to mid-bit in START, so every full bit period
        // from here on lands at mid-bit. Bits enter at the MSB and shift right,
        // which leaves the first bit on the wire in bit 0 after the last shift.
        DATA: begin
          if (bit_done) begin
            clk_cnt   <= '0;
            shift_reg <= {sync_2, shift_reg[7:1]};
            if (bit_cnt == BITS_LAST) begin
              bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (bit_done) begin
            clk_cnt    <= '0;
            parity_bit <= sync_2;
            state      <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (sync_2) begin
              state <= LOAD;
            end else begin
              framing_error <= 1'b1;
`ifdef PARITY_CHECK_EN
              parity_error  <= 1'b0;
`endif
              state         <= WAIT_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        LOAD: begin
          packet_data   <= shift_reg;
          load_buffer   <= 1'b1;
          framing_error <= 1'b0;
`ifdef PARITY_CHECK_EN
          parity_error  <= ((^shift_reg) != parity_bit);
`endif
          state         <= IDLE;
        end

        // A failed stop bit may mean a break or a stuck-low line.
        // Wait for the line to return high so the low level is not mistaken for a new start bit.
        WAIT_IDLE: begin
          clk_cnt <= '0;
          if (sync_2) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// tb_rx_packet_ctrl
//   Randomised and directed bench for rx_packet_ctrl.
//   The bench drives whole serial frames and predicts each outcome from the frame contents.
//   The predicted outcome covers whether a strobe occurs, the strobe cycle, the data and the sticky flags.
module tb_rx_packet_ctrl;

  localparam int C    = 10;
  localparam int HALF = C / 2;
`ifdef PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Strobe latency from the first edge that samples the start bit low.
  localparam int LAT = 3 + HALF + (8 + 1 + PB) * C;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] packet_data;
  logic       load_buffer;
  logic       framing_error;
  logic       parity_error;
  logic       rx_busy;

  rx_packet_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .packet_data   (packet_data),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [7:0]  data;
  } strobe_t;

  strobe_t sq[$];
  always @(negedge clk) if (load_buffer === 1'b1) sq.push_back('{cyc, packet_data});

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_pkt = 8'hFF;
  logic        exp_fe  = 1'b0;
  logic        exp_pe  = 1'b0;
  int unsigned last_at = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic hold(input logic v, input int n);
    serial_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs(input logic busy);
    check("packet_data", packet_data, exp_pkt);
    check("framing_error", framing_error, exp_fe);
    check("parity_error", parity_error, exp_pe);
    check("rx_busy", rx_busy, busy);
    check("load_buffer_idle", load_buffer, 1'b0);
  endtask

  // Must be entered at a negedge. The frame's N is the next rising edge.
  task automatic run_frame(input logic [7:0] d, input logic par, input logic stop);
    int unsigned n;
    strobe_t     s;
    n = cyc + 1;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(d[i], C);
`ifdef PARITY_CHECK_EN
    hold(par, C);
`endif
    hold(stop, C);
    if (stop) begin
      check("strobe_count", sq.size(), 1);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        check("strobe_cycle", s.at, n + LAT);
        check("strobe_data", s.data, d);
        last_at = s.at;
      end
      exp_pkt = d;
      exp_fe  = 1'b0;
      exp_pe  = (PB == 1) ? ((^d) != par) : 1'b0;
    end else begin
      check("no_strobe_on_bad_stop", sq.size(), 0);
      exp_fe = 1'b0 | 1'b1;
      exp_pe = 1'b0;
    end
    sq.delete();
    check_outputs(!stop);
  endtask

  // Short low pulse on an idle line: the FSM leaves IDLE briefly and then drops the frame.
  task automatic glitch(input int len);
    int unsigned n;
    n = cyc + 1;
    hold(1'b0, len);
    hold(1'b1, int'(n + 3 - cyc));
    check("glitch_busy", rx_busy, 1'b1);
    hold(1'b1, 10);
    check("glitch_no_strobe", sq.size(), 0);
    sq.delete();
    check_outputs(1'b0);
  endtask

  initial begin
    logic [7:0]  d;
    logic        stop;
    logic        par;
    int unsigned first_at;

    serial_in = 1'b1;
    n_rst     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_packet_data", packet_data, 8'hFF);
    check("rst_load_buffer", load_buffer, 1'b0);
    check("rst_framing_error", framing_error, 1'b0);
    check("rst_parity_error", parity_error, 1'b0);
    check("rst_rx_busy", rx_busy, 1'b0);
    n_rst = 1'b1;
    hold(1'b1, 5);

    // Good frame with matching parity.
    run_frame(8'hA5, ^8'hA5, 1'b1);
    hold(1'b1, 5);

    // Bad stop bit, then a stuck-low line held in WAIT_IDLE, then recovery.
    run_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 30);
    check("wait_idle_busy", rx_busy, 1'b1);
    check("wait_idle_no_strobe", sq.size(), 0);
    hold(1'b1, 5);
    check("wait_idle_released", rx_busy, 1'b0);
    run_frame(8'h81, ^8'h81, 1'b1);
    hold(1'b1, 4);

    glitch(3);

    // Back-to-back frames: the second start bit follows the stop bit directly.
    run_frame(8'h00, 1'b0, 1'b1);
    first_at = last_at;
    run_frame(8'hFF, 1'b0, 1'b1);
    check("back_to_back_spacing", last_at - first_at, (10 + PB) * C);
    hold(1'b1, 5);

    // Reset in the middle of data bit 4 of a 0x55 frame.
    d = 8'h55;
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(d[i], C);
    hold(d[4], 3);
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst_packet_data", packet_data, 8'hFF);
    check("midrst_load_buffer", load_buffer, 1'b0);
    check("midrst_framing_error", framing_error, 1'b0);
    check("midrst_parity_error", parity_error, 1'b0);
    check("midrst_rx_busy", rx_busy, 1'b0);
    hold(1'b1, 3);
    n_rst = 1'b1;
    hold(1'b1, 5);
    check("midrst_no_strobe", sq.size(), 0);
    sq.delete();
    exp_pkt = 8'hFF;
    exp_fe  = 1'b0;
    exp_pe  = 1'b0;
    run_frame(8'h0F, ^8'h0F, 1'b1);
    hold(1'b1, 3);

`ifdef PARITY_CHECK_EN
    run_frame(8'h07, 1'b0, 1'b1);
    check("parity_bad_flag", parity_error, 1'b1);
    hold(1'b1, 3);
    run_frame(8'h07, 1'b1, 1'b1);
    check("parity_good_flag", parity_error, 1'b0);
    hold(1'b1, 3);
`endif

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      par  = 1'($urandom_range(0, 1));
      run_frame(d, par, stop);
      if (!stop) begin
        if ($urandom_range(0, 2) == 0) hold(1'b0, $urandom_range(5, 40));
        hold(1'b1, $urandom_range(3, 8));
      end else begin
        hold(1'b1, $urandom_range(0, 6));
      end
      if ($urandom_range(0, 5) == 0) begin
        hold(1'b1, 2);
        glitch($urandom_range(1, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
